// File: rtl/alu_decode_if.sv
// alu_decode_if
//   Handshake and data bundle between fetch, the decode stage and execute.
//   Upstream side : in_valid, in_ready, in_instr, in_pc.
//   Downstream side: out_valid, out_ready and the decoded fields
//                    (out_alu_op, out_sel_a, out_sel_b, out_imm, out_rs1,
//                    out_rs2, out_rd, out_reg_write, out_illegal, out_pc).
//   slave  : view taken by the decode stage.
//   master : view taken by the environment around it (fetch + execute).
interface alu_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_sel_a;
  logic        out_sel_b;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;
  logic [31:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_sel_a, out_sel_b, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_illegal, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_sel_a, out_sel_b, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Registered RV32I decode stage in front of the ALU. Instructions arrive on
//   a valid/ready handshake, are decoded combinationally and captured into a
//   two-entry skid buffer (main + skid). Outputs always show the main entry.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     flush : synchronous clear of all buffered entries (wins over transfers)
//     bus   : alu_decode_if.slave, upstream and downstream handshakes + fields

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

package alu_decode_pkg;
  typedef enum logic [1:0] {
    SEL_A_RS1  = 2'b00,
    SEL_A_PC   = 2'b01,
    SEL_A_ZERO = 2'b10
  } sel_a_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_decode_if.slave  bus
);

  // funct3 -> op code; alt selects SUB/SRA for the funct7=0100000 variants
  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? `ALU_SUB : `ALU_ADD;
      3'b001:  op = `ALU_SLL;
      3'b010:  op = `ALU_SLT;
      3'b011:  op = `ALU_SLTU;
      3'b100:  op = `ALU_XOR;
      3'b101:  op = alt ? `ALU_SRA : `ALU_SRL;
      3'b110:  op = `ALU_OR;
      default: op = `ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  entry_t      dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin : decode
    // NOTE: every field gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    dec           = '0;
    dec.alu_op    = `ALU_ADD;
    dec.sel_a     = SEL_A_RS1;
    dec.sel_b     = 1'b0;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.pc        = bus.in_pc;

    unique case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_BASE)
          dec.alu_op = base_op(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_op = base_op(funct3, 1'b1);
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.sel_b     = 1'b1;
        dec.imm       = imm_i;
        // Only the shifts constrain funct7; for the rest it is immediate bits.
        if (funct3 == 3'b001) begin
          dec.alu_op  = `ALU_SLL;
          dec.illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     dec.alu_op = `ALU_SRL;
          else if (funct7 == F7_ALT) dec.alu_op = `ALU_SRA;
          else                       dec.illegal = 1'b1;
        end else begin
          dec.alu_op = base_op(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        dec.sel_a     = SEL_A_ZERO;
        dec.sel_b     = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.sel_a     = SEL_A_PC;
        dec.sel_b     = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec.sel_b     = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.sel_b = 1'b1;
        dec.imm   = imm_s;
      end
      // Covers unknown opcodes and any instr[1:0] != 2'b11.
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.alu_op    = `ALU_ADD;
      dec.reg_write = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------------
  buf_state_e state_q, state_d;
  entry_t     main_q,  main_d;
  entry_t     skid_q,  skid_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       in_xfer;
  logic       out_xfer;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin : buf_next
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = dec;
          end else if (in_xfer) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Handshake flags are registered from the next state so in_ready has no
    // combinational path from out_ready.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // NOTE: the buffer entries are reset too, because every data output must
  // read as zero during reset, not just the valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_alu_op    = main_q.alu_op;
  assign bus.out_sel_a     = main_q.sel_a;
  assign bus.out_sel_b     = main_q.sel_b;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_rs1       = main_q.rs1;
  assign bus.out_rs2       = main_q.rs2;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_q.reg_write;
  assign bus.out_illegal   = main_q.illegal;
  assign bus.out_pc        = main_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
//   Scoreboard bench: the driver pushes hand-computed expected entries when an
//   input handshake is certain; a monitor compares the head of the queue with
//   the outputs whenever out_valid is high and pops on an output handshake.
module tb_alu_decode_stage;

  // ALU op codes shared with the ALU
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2,
                         OP_SRA = 4'd7, OP_OR  = 4'd8;

  // Expected entry: value and care-mask over the packed output word
  // {alu_op, sel_a, sel_b, imm, rs1, rs2, rd, reg_write, illegal, pc} (88 b)
  typedef struct {
    logic [87:0] v;
    logic [87:0] m;
  } exp_t;

  localparam int K_FULL = 0, K_NO_IMM = 1, K_ILL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  alu_decode_if bus ();

  alu_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [87:0] out_word();
    return {bus.out_alu_op, bus.out_sel_a, bus.out_sel_b, bus.out_imm,
            bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_reg_write,
            bus.out_illegal, bus.out_pc};
  endfunction

  function automatic exp_t mk(input logic [3:0] op, input logic [1:0] sa,
                              input logic sb, input logic [31:0] imm,
                              input logic [4:0] rs1, rs2, rd,
                              input logic rw, ill, input logic [31:0] pc,
                              input int kind);
    exp_t e;
    e.v = {op, sa, sb, imm, rs1, rs2, rd, rw, ill, pc};
    e.m = '1;
    if (kind == K_NO_IMM) e.m[80:49] = '0;
    if (kind == K_ILL)    e.m[83:49] = '0;
    return e;
  endfunction

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare head while valid (also proves stability under stall)
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", out_word());
        end else begin
          check("scoreboard", out_word() & exp_q[0].m, exp_q[0].v & exp_q[0].m);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drive one instruction until accepted (bounded); push expectation if kept
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    for (int n = 0; n < 30 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (!flush) exp_q.push_back(e);
        acc = 1;
      end
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: instr %h never accepted", instr);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check(name, 88'(exp_q.size()), 88'd0);
  endtask

  initial begin
    int t0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", out_word(), 88'd0);
    check("reset_out_valid", 88'(bus.out_valid), 88'd0);
    check("reset_in_ready", 88'(bus.in_ready), 88'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type back to back, then immediates, U-type, loads/stores, illegals
    t0 = cyc;
    send(32'h002081B3, 32'h0000_0100, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h100, K_NO_IMM));
    send(32'h402081B3, 32'h0000_0104, mk(OP_SUB, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h104, K_NO_IMM));
    send(32'h0020E1B3, 32'h0000_0108, mk(OP_OR,  2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h108, K_NO_IMM));
    send(32'hFFF00293, 32'h0000_010C, mk(OP_ADD, 2'b00, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 1, 0, 32'h10C, K_FULL));
    check("throughput_cycles", 88'(cyc - t0), 88'd4);
    send(32'h4043D313, 32'h0000_0110, mk(OP_SRA, 2'b00, 1'b1, 32'h0000_0404, 5'd7, 5'd4, 5'd6, 1, 0, 32'h110, K_FULL));
    send(32'h123450B7, 32'h0000_0114, mk(OP_ADD, 2'b10, 1'b1, 32'h1234_5000, 5'd8, 5'd3, 5'd1, 1, 0, 32'h114, K_FULL));
    send(32'h12345097, 32'hCAFE_0000, mk(OP_ADD, 2'b01, 1'b1, 32'h1234_5000, 5'd8, 5'd3, 5'd1, 1, 0, 32'hCAFE_0000, K_FULL));
    send(32'h0080A283, 32'h0000_011C, mk(OP_ADD, 2'b00, 1'b1, 32'h0000_0008, 5'd1, 5'd8, 5'd5, 1, 0, 32'h11C, K_FULL));
    send(32'hFE20AE23, 32'h0000_0120, mk(OP_ADD, 2'b00, 1'b1, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd28, 0, 0, 32'h120, K_FULL));
    send(32'h202081B3, 32'h0000_0124, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 0, 1, 32'h124, K_ILL));
    send(32'h0000007F, 32'h0000_0128, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h128, K_ILL));
    send(32'h40209093, 32'h0000_012C, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd1, 0, 1, 32'h12C, K_ILL));
    send(32'h00000010, 32'h0000_0130, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h130, K_ILL));
    drain("drain_decode");

    // Backpressure: two accepted, in_ready drops, third waits, FIFO order
    bus.out_ready = 1'b0;
    send(32'h00208033, 32'h0000_0200, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd0, 1, 0, 32'h200, K_NO_IMM));
    send(32'h00209033, 32'h0000_0204, mk(OP_SLL, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd0, 1, 0, 32'h204, K_NO_IMM));
    @(negedge clk);
    check("bp_in_ready_low", 88'(bus.in_ready), 88'd0);
    check("bp_out_valid", 88'(bus.out_valid), 88'd1);
    @(posedge clk);
    #1;
    fork
      send(32'h4020D033, 32'h0000_0208, mk(OP_SRA, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd0, 1, 0, 32'h208, K_NO_IMM));
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Flush while FULL: head consumed in flush cycle, skid and new input dropped
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h0000_0300, mk(OP_ADD, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h300, K_NO_IMM));
    send(32'h402081B3, 32'h0000_0304, mk(OP_SUB, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h304, K_NO_IMM));
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0020E1B3;
    bus.in_pc     = 32'h0000_0308;
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 88'(bus.out_valid), 88'd0);
    check("flush_in_ready", 88'(bus.in_ready), 88'd1);
    @(negedge clk);
    check("flush_input_dropped", 88'(bus.out_valid), 88'd0);
    @(posedge clk);
    #1;
    send(32'h12345097, 32'h0000_0400, mk(OP_ADD, 2'b01, 1'b1, 32'h1234_5000, 5'd8, 5'd3, 5'd1, 1, 0, 32'h400, K_FULL));
    drain("drain_after_flush");

    // Asynchronous reset mid-stream: outputs clear without a clock edge
    bus.out_ready = 1'b0;
    send(32'h0080A283, 32'h0000_0500, mk(OP_ADD, 2'b00, 1'b1, 32'h0000_0008, 5'd1, 5'd8, 5'd5, 1, 0, 32'h500, K_FULL));
    send(32'hFFF00293, 32'h0000_0504, mk(OP_ADD, 2'b00, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 1, 0, 32'h504, K_FULL));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_reset_data", out_word(), 88'd0);
    check("async_reset_out_valid", 88'(bus.out_valid), 88'd0);
    check("async_reset_in_ready", 88'(bus.in_ready), 88'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0020E1B3, 32'h0000_0600, mk(OP_OR, 2'b00, 1'b0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'h600, K_NO_IMM));
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
